// File: rtl/audio_pkg.sv
// Shared types for the playback stage: the playback FSM states and the
// encodings of the underflow output policy.
package audio_pkg;

   typedef enum logic {
      PRIMING = 1'b0,
      PLAYING = 1'b1
   } playback_state_e;

   localparam int UF_ZERO   = 0;
   localparam int UF_REPEAT = 1;

endpackage

// File: rtl/playback_ram.sv
// Simple dual-port sample store: one write port and one registered read port.
// The read register only loads on rd_en_i, so it keeps the most recently read word.
module playback_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4400,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_in,
   input  logic                  wr_en_i,
   input  logic [AW-1:0]         wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [AW-1:0]         rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk_in) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read-first: a same-address write in the read cycle returns the old word,
   // which is what a full buffer needs when it reads and writes slot rd_ptr together.
   always_ff @(posedge clk_in) begin
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/playback_bufferizer.sv
// Circular playback buffer: absorbs a bursty sample stream, then after priming
// replays one sample every PLAY_PERIOD cycles with occupancy and over/underflow status.
module playback_bufferizer
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH          = 4400,
   parameter int PRIME_LEVEL    = 2304,
   parameter int PLAY_PERIOD    = 2304,
   parameter int UNDERFLOW_MODE = 0,
   parameter int REPRIME        = 1
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         flush_in,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         data_valid_in,
   output logic [DATA_WIDTH-1:0]        audio_out,
   output logic                         audio_valid_out,
   output logic [$clog2(DEPTH+1)-1:0]   fill_level_out,
   output logic                         playing_out,
   output logic                         overflow_out,
   output logic                         underflow_out
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(PLAY_PERIOD);

   localparam logic [AW-1:0] PTR_LAST   = AW'(DEPTH - 1);
   localparam logic [FW-1:0] FILL_FULL  = FW'(DEPTH);
   localparam logic [FW-1:0] FILL_PRIME = FW'(PRIME_LEVEL);
   localparam logic [TW-1:0] TICK_LAST  = TW'(PLAY_PERIOD - 1);

   playback_state_e state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]   fill_q, fill_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic            tick_q, tick_d;
   logic            valid_q, valid_d;
   logic            src_ram_q, src_ram_d;

   logic                  clear;
   logic                  empty;
   logic                  full;
   logic                  rd_en;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] ram_rdata;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign clear = rst_in | flush_in;
   assign empty = (fill_q == '0);
   assign full  = (fill_q == FILL_FULL);

   // A full buffer still accepts a write when the same cycle frees a slot.
   assign rd_en = tick_q & ~empty & ~clear;
   assign wr_en = data_valid_in & ~clear & (~full | rd_en);

   playback_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk_in    (clk_in),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (data_in),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (ram_rdata)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (wr_en) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (rd_en) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({wr_en, rd_en})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase
   end

   // The tick is registered from the counter, so the first one lands
   // PLAY_PERIOD cycles after entering PLAYING and reads happen in the tick cycle.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = '0;
      tick_d     = 1'b0;
      case (state_q)
         PRIMING: begin
            if (fill_d >= FILL_PRIME) begin
               state_d = PLAYING;
            end
         end
         PLAYING: begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
            tick_d     = (tick_cnt_q == TICK_LAST);
            if (tick_q && empty && (REPRIME != 0)) begin
               state_d    = PRIMING;
               tick_cnt_d = '0;
            end
         end
         default: state_d = PRIMING;
      endcase
   end

   // The RAM read register holds the last sample actually read, so it doubles
   // as the repeat value; src_ram_q only chooses between it and zero.
   always_comb begin
      valid_d   = tick_q;
      src_ram_d = src_ram_q;
      if (rd_en) begin
         src_ram_d = 1'b1;
      end else if (tick_q && (UNDERFLOW_MODE == UF_ZERO)) begin
         src_ram_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (clear) begin
         state_q    <= PRIMING;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
         valid_q    <= 1'b0;
         src_ram_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         tick_cnt_q <= tick_cnt_d;
         tick_q     <= tick_d;
         valid_q    <= valid_d;
         src_ram_q  <= src_ram_d;
      end
   end

   assign audio_out       = src_ram_q ? ram_rdata : '0;
   assign audio_valid_out = valid_q & ~clear;
   assign fill_level_out  = fill_q;
   assign playing_out     = (state_q == PLAYING);
   assign overflow_out    = data_valid_in & ~clear & full & ~rd_en;
   assign underflow_out   = tick_q & empty & ~clear;

endmodule

// File: tb/tb_playback_bufferizer.sv
// Bench for playback_bufferizer: three parameter variants share one stimulus
// stream and are compared every cycle against a queue-based playback model.
module tb_playback_bufferizer;

   localparam int NI      = 3;
   localparam int T_DEPTH = 8;
   localparam int T_PER   = 4;

   logic clk;
   logic rst, flush, dv;
   logic [15:0] din;

   logic [NI-1:0][15:0] aud;
   logic [NI-1:0][3:0]  fill;
   logic [NI-1:0]       av, play, ov, uf;

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  cmp_en   = 0;

   // Reference state: contents as a plain queue, cycles spent playing,
   // the strobe due this cycle, the held output and the last sample read.
   int unsigned mq [NI][$];
   bit          m_play [NI];
   int          m_age  [NI];
   bit          m_pend [NI];
   int unsigned m_aud  [NI];
   int unsigned m_last [NI];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_dut
         playback_bufferizer #(
            .DATA_WIDTH     (16),
            .DEPTH          (T_DEPTH),
            .PRIME_LEVEL    ((gi == 1) ? 8 : 4),
            .PLAY_PERIOD    (T_PER),
            .UNDERFLOW_MODE ((gi == 2) ? 1 : 0),
            .REPRIME        ((gi == 2) ? 0 : 1)
         ) u_dut (
            .clk_in          (clk),
            .rst_in          (rst),
            .flush_in        (flush),
            .data_in         (din),
            .data_valid_in   (dv),
            .audio_out       (aud[gi]),
            .audio_valid_out (av[gi]),
            .fill_level_out  (fill[gi]),
            .playing_out     (play[gi]),
            .overflow_out    (ov[gi]),
            .underflow_out   (uf[gi])
         );
      end
   endgenerate

   function automatic int prime_of(input int k);
      return (k == 1) ? 8 : 4;
   endfunction

   function automatic bit repeat_mode(input int k);
      return (k == 2);
   endfunction

   function automatic bit reprime_of(input int k);
      return (k != 2);
   endfunction

   task automatic chk(input string name, input int inst,
                      input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, inst, $time, act, exp);
      end
   endtask

   // Compare then advance the model, once per cycle, away from the active edge.
   always @(negedge clk) begin
      bit          clr, tick, rd;
      int          sz;
      int unsigned v;
      if (cmp_en) begin
         for (int k = 0; k < NI; k++) begin
            clr  = rst || flush;
            sz   = mq[k].size();
            tick = m_play[k] && (m_age[k] > 0) && ((m_age[k] % T_PER) == 0);
            rd   = tick && (sz > 0) && !clr;
            chk("audio_valid", k, av[k], m_pend[k] && !clr);
            chk("audio_out", k, aud[k], m_aud[k]);
            chk("fill_level", k, fill[k], sz);
            chk("playing", k, play[k], m_play[k]);
            chk("overflow", k, ov[k], dv && !clr && (sz == T_DEPTH) && !rd);
            chk("underflow", k, uf[k], tick && (sz == 0) && !clr);
            if (clr) begin
               mq[k].delete();
               m_play[k] = 0;
               m_age[k]  = 0;
               m_pend[k] = 0;
               m_aud[k]  = 0;
               m_last[k] = 0;
            end else begin
               if (rd) begin
                  v = mq[k].pop_front();
                  m_last[k] = v;
               end else begin
                  v = repeat_mode(k) ? m_last[k] : 0;
               end
               if (dv && ((sz < T_DEPTH) || rd)) mq[k].push_back(int'(din));
               m_pend[k] = tick;
               if (tick) m_aud[k] = v;
               if (m_play[k]) begin
                  if (tick && (sz == 0) && reprime_of(k)) begin
                     m_play[k] = 0;
                     m_age[k]  = 0;
                  end else begin
                     m_age[k]++;
                  end
               end else if (mq[k].size() >= prime_of(k)) begin
                  m_play[k] = 1;
                  m_age[k]  = 0;
               end
            end
         end
      end
   end

   task automatic drive(input bit r, input bit f, input bit v, input int unsigned d);
      @(posedge clk);
      #1;
      rst   = r;
      flush = f;
      dv    = v;
      din   = 16'(d);
      #2;
   endtask

   // Wait for a strobe cycle and assert flush or reset inside it.
   task automatic clear_on_strobe(input bit use_rst);
      bit found;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk);
         #1;
         dv = 0;
         if (m_pend[0]) begin
            found = 1;
            if (use_rst) rst = 1;
            else flush = 1;
         end
         #2;
         if (found) chk("clear_no_strobe", 0, av[0], 0);
      end
      chk("clear_strobe_wait", 0, found, 1);
      drive(0, 0, 0, 0);
      for (int k = 0; k < NI; k++) begin
         chk("clear_fill", k, fill[k], 0);
         chk("clear_playing", k, play[k], 0);
         if (use_rst) begin
            chk("rst_audio", k, aud[k], 0);
            chk("rst_valid", k, av[k], 0);
            chk("rst_ovf", k, ov[k], 0);
            chk("rst_udf", k, uf[k], 0);
         end
      end
   endtask

   int sv_cyc [4] = '{10, 14, 18, 22};
   int sv_val [4] = '{1, 2, 3, 'hAB};

   initial begin
      int rate;
      rst = 1; flush = 0; dv = 0; din = '0;
      for (int k = 0; k < NI; k++) begin
         m_play[k] = 0; m_age[k] = 0; m_pend[k] = 0; m_aud[k] = 0; m_last[k] = 0;
      end
      drive(1, 0, 0, 0);
      cmp_en = 1;
      chk("reset_fill", 0, fill[0], 0);
      chk("reset_playing", 0, play[0], 0);
      drive(1, 0, 0, 0);

      // Priming, drain, underflow in both policies.
      for (int k = 1; k <= 30; k++) begin
         drive(0, 0, k <= 4, (k == 4) ? 'hAB : k);
         if (k == 4) chk("p1_play_before", 0, play[0], 0);
         if (k == 5) begin
            chk("p1_play_rise", 0, play[0], 1);
            chk("p1_fill_primed", 0, fill[0], 4);
         end
         for (int i = 0; i < 4; i++) begin
            if (k == sv_cyc[i]) begin
               chk("p1_strobe", 0, av[0], 1);
               chk("p1_sample", 0, aud[0], sv_val[i]);
               chk("p1_fill", 0, fill[0], 3 - i);
            end
         end
         if (k == 11) chk("p1_no_strobe", 0, av[0], 0);
         if (k == 25) begin
            chk("p1_udf_zero", 0, uf[0], 1);
            chk("p1_udf_rep", 2, uf[2], 1);
         end
         if (k == 26) begin
            chk("p1_udf_strobe", 0, av[0], 1);
            chk("p1_udf_value", 0, aud[0], 0);
            chk("p1_reprime", 0, play[0], 0);
            chk("p1_rep_strobe", 2, av[2], 1);
            chk("p1_rep_value", 2, aud[2], 'hAB);
            chk("p1_keep_play", 2, play[2], 1);
         end
         if (k == 29) chk("p1_udf_again", 2, uf[2], 1);
         if (k == 30) chk("p1_rep_value2", 2, aud[2], 'hAB);
      end

      // Overflow on a priming-to-full buffer (instance 1 primes at 8).
      drive(1, 0, 0, 0);
      for (int k = 1; k <= 50; k++) begin
         drive(0, 0, k <= 10, k);
         if (k == 8) chk("p2_no_ovf", 1, ov[1], 0);
         if (k == 9) begin
            chk("p2_fill_full", 1, fill[1], 8);
            chk("p2_ovf9", 1, ov[1], 1);
         end
         if (k == 10) chk("p2_ovf10", 1, ov[1], 1);
         if (k == 14) chk("p2_first_out", 1, aud[1], 1);
         if (k == 42) chk("p2_last_out", 1, aud[1], 8);
      end

      // Full buffer with simultaneous read and write; pointer wrap.
      drive(1, 0, 0, 0);
      for (int k = 1; k <= 44; k++) begin
         drive(0, 0, k <= 9, 'h20 + k);
         if (k == 9) begin
            chk("p3_fill_full", 0, fill[0], 8);
            chk("p3_no_ovf", 0, ov[0], 0);
         end
         if (k == 10) begin
            chk("p3_fill_held", 0, fill[0], 8);
            chk("p3_first", 0, aud[0], 'h21);
         end
         if (k == 42) begin
            chk("p3_wrapped", 0, aud[0], 'h29);
            chk("p3_drained", 0, fill[0], 0);
         end
      end

      // Flush and reset on a strobe cycle.
      drive(1, 0, 0, 0);
      for (int k = 1; k <= 6; k++) drive(0, 0, 1, 'h40 + k);
      clear_on_strobe(0);
      for (int k = 1; k <= 6; k++) drive(0, 0, 1, 'h50 + k);
      clear_on_strobe(1);

      // Randomised traffic with varying input rate and occasional clears.
      rate = 25;
      for (int c = 0; c < 4000; c++) begin
         if ((c % 250) == 0) begin
            case ($urandom_range(0, 3))
               0:       rate = 10;
               1:       rate = 25;
               2:       rate = 50;
               default: rate = 90;
            endcase
         end
         drive($urandom_range(0, 999) < 3, $urandom_range(0, 299) == 0,
               $urandom_range(0, 99) < rate, $urandom);
      end

      drive(0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
